// File: rtl/prio_arbiter.sv
// prio_arbiter: registered priority arbiter with a valid/ready grant handshake.
//
// Scan order for the winner search is (ptr-1-k) mod IN_WIDTH, k = 0..IN_WIDTH-1.
// With ptr = 0 this means the highest set request index wins.
//
// Build option:
//   PRIO_ARBITER_RR_EN  defined   -> round-robin. ptr follows the last accepted
//                                    index, so the requester just served has the
//                                    lowest priority.
//                       undefined -> fixed priority. ptr is tied to 0 and no
//                                    ptr register exists.
//
// Parameters:
//   OUT_WIDTH   grant index width, legal range 1..6; IN_WIDTH = 1 << OUT_WIDTH
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous reset, active high
//   req         request vector, bit i = requester i wants a grant
//   gnt_valid   a grant is being offered on gnt_idx/gnt_onehot
//   gnt_ready   consumer accepts the offered grant (ignored while gnt_valid=0)
//   gnt_idx     binary index of the granted requester (kept after going idle)
//   gnt_onehot  one-hot form of gnt_idx, all zero while idle
//
// States:
//   S_IDLE  | no grant is offered; wait for any request
//   S_GRANT | grant is offered and held until it is accepted

module prio_arbiter #(
  parameter int OUT_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(1<<OUT_WIDTH)-1:0]   req,
  output logic                        gnt_valid,
  input  logic                        gnt_ready,
  output logic [OUT_WIDTH-1:0]        gnt_idx,
  output logic [(1<<OUT_WIDTH)-1:0]   gnt_onehot
);

  localparam int IN_WIDTH = 1 << OUT_WIDTH;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e                state_q, state_d;
  logic [OUT_WIDTH-1:0]  gnt_idx_q, gnt_idx_d;
  logic [IN_WIDTH-1:0]   gnt_onehot_q, gnt_onehot_d;
  logic                  hs;
  logic [OUT_WIDTH-1:0]  ptr_scan;
  logic [OUT_WIDTH-1:0]  win_idx;
  logic [OUT_WIDTH-1:0]  cand;
  logic                  found;

  assign hs = (state_q == S_GRANT) && gnt_ready;

`ifdef PRIO_ARBITER_RR_EN
  logic [OUT_WIDTH-1:0] ptr_q, ptr_d;

  // The winner picked on an accepting edge must already treat the accepted
  // index as lowest priority, so the scan uses the next pointer value.
  always_comb begin
    ptr_d    = hs ? gnt_idx_q : ptr_q;
    ptr_scan = ptr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign ptr_scan = '0;
`endif

  // The index arithmetic wraps modulo IN_WIDTH because it is only OUT_WIDTH bits wide.
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      cand = ptr_scan - OUT_WIDTH'(1) - OUT_WIDTH'(k);
      if (!found && req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d      = S_GRANT;
          gnt_idx_d    = win_idx;
          gnt_onehot_d = {{(IN_WIDTH-1){1'b0}}, 1'b1} << win_idx;
        end
      end
      S_GRANT: begin
        if (hs) begin
          if (|req) begin
            gnt_idx_d    = win_idx;
            gnt_onehot_d = {{(IN_WIDTH-1){1'b0}}, 1'b1} << win_idx;
          end else begin
            state_d      = S_IDLE;
            gnt_onehot_d = '0;
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        gnt_onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
    end
  end

  assign gnt_valid  = (state_q == S_GRANT);
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter: an 8-requester instance and a 2-requester
// instance share clock and reset. Expected values are hand-computed; where the
// round-robin build differs from the fixed-priority build, both are listed.

module tb_prio_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       gnt_ready;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;

  logic [1:0] req2;
  logic       gnt_ready2;
  logic       gnt_valid2;
  logic       gnt_idx2;
  logic [1:0] gnt_onehot2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  prio_arbiter #(.OUT_WIDTH(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  prio_arbiter #(.OUT_WIDTH(1)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .req        (req2),
    .gnt_valid  (gnt_valid2),
    .gnt_ready  (gnt_ready2),
    .gnt_idx    (gnt_idx2),
    .gnt_onehot (gnt_onehot2)
  );

`ifdef PRIO_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] idx);
    chk({tag, " valid"}, 32'(gnt_valid), 32'd1);
    chk({tag, " idx"}, 32'(gnt_idx), 32'(idx));
    chk({tag, " onehot"}, 32'(gnt_onehot), 32'(8'd1 << idx));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " valid"}, 32'(gnt_valid), 32'd0);
    chk({tag, " onehot"}, 32'(gnt_onehot), 32'd0);
  endtask

  logic [2:0] rr_seq [9];
  logic [1:0] rr_seq2 [3];

  initial begin
    rr_seq  = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    rr_seq2 = '{2'd1, 2'd0, 2'd1};

    rst = 1'b1; req = '0; gnt_ready = 1'b0; req2 = '0; gnt_ready2 = 1'b0;
    tick();
    chk_idle("reset");
    chk("reset idx", 32'(gnt_idx), 32'd0);
    rst = 1'b0;

    // No requests: stay idle, even with gnt_ready high.
    for (int i = 0; i < 10; i++) begin
      gnt_ready = (i % 2 == 1);
      tick();
      chk_idle($sformatf("noreq c%0d", i));
    end
    gnt_ready = 1'b0;

    // 8'h24 -> highest set index 5 wins.
    req = 8'h24;
    tick();
    chk_grant("req24", 3'd5);

    // Held while not ready, including after req bit 5 drops.
    req = 8'h80; tick(); chk_grant("hold80", 3'd5);
    req = 8'h00; tick(); chk_grant("hold00a", 3'd5);
    tick();              chk_grant("hold00b", 3'd5);

    // Accept with no request pending -> idle, index retained.
    gnt_ready = 1'b1;
    tick();
    chk_idle("accept idle");
    chk("accept idle idx", 32'(gnt_idx), 32'd5);
    tick();
    chk_idle("ready ignored");

    // Reset overrides a same-cycle request, then a full sweep with req=8'hFF.
    rst = 1'b1; req = 8'hFF;
    tick();
    chk_idle("rst over req");
    chk("rst over req idx", 32'(gnt_idx), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_grant($sformatf("sweep%0d", i), RR ? rr_seq[i] : 3'd7);
    end

    // Set up ptr=3 (RR), leave grant 2 pending, then reset mid-grant.
    rst = 1'b1; req = 8'h00; gnt_ready = 1'b0;
    tick();
    rst = 1'b0; req = 8'h08;
    tick();
    chk_grant("pre3", 3'd3);
    gnt_ready = 1'b1; req = 8'h04;
    tick();
    chk_grant("pre2", 3'd2);
    gnt_ready = 1'b0;
    tick();
    chk_grant("pend2", 3'd2);
    rst = 1'b1;
    tick();
    chk_idle("rst mid");
    chk("rst mid idx", 32'(gnt_idx), 32'd0);
    rst = 1'b0; req = 8'h09;
    tick();
    chk_grant("post rst", 3'd3);

    // Back-to-back accepts with req=8'h06: RR rotates 2 then 1, fixed stays 2.
    gnt_ready = 1'b1; req = 8'h06;
    tick();
    chk_grant("b2b a", 3'd2);
    tick();
    chk_grant("b2b b", RR ? 3'd1 : 3'd2);

    // Two-requester instance.
    gnt_ready = 1'b0; req = 8'h00;
    rst = 1'b1;
    tick();
    chk("w1 rst valid", 32'(gnt_valid2), 32'd0);
    rst = 1'b0; req2 = 2'b11; gnt_ready2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("w1 alt%0d valid", i), 32'(gnt_valid2), 32'd1);
      chk($sformatf("w1 alt%0d idx", i), 32'(gnt_idx2), RR ? 32'(rr_seq2[i]) : 32'd1);
      chk($sformatf("w1 alt%0d onehot", i), 32'(gnt_onehot2),
          RR ? 32'(2'd1 << rr_seq2[i]) : 32'd2);
    end
    req2 = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("w1 lo%0d idx", i), 32'(gnt_idx2), 32'd0);
      chk($sformatf("w1 lo%0d onehot", i), 32'(gnt_onehot2), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 Parameter OUT_WIDTH, default 3: grant index width; derived IN_WIDTH = 1 << OUT_WIDTH requesters; legal OUT_WIDTH 1..6.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  IN_WIDTH  request vector; bit i = requester i wants a grant.
REQ-005 gnt_valid  output  1  registered; grant held in gnt_idx/gnt_onehot is valid.
REQ-006 gnt_ready  input  1  consumer accepts the current grant when high with gnt_valid.
REQ-007 gnt_idx  output  OUT_WIDTH  registered binary index of the granted requester.
REQ-008 gnt_onehot  output  IN_WIDTH  registered one-hot form of gnt_idx; all zero when gnt_valid=0.

Function
REQ-009 Two-state FSM: IDLE (gnt_valid=0), GRANT (gnt_valid=1).
REQ-010 Winner search: scan indices (ptr-1-k) mod IN_WIDTH for k = 0..IN_WIDTH-1, first set req bit wins; ptr is an OUT_WIDTH-bit internal register.
REQ-011 With ptr=0 the scan order is IN_WIDTH-1 down to 0, i.e. highest set index wins.
REQ-012 IDLE with |req=1: load winner into gnt_idx/gnt_onehot, go GRANT; gnt_valid rises exactly 1 cycle after req is sampled.
REQ-013 IDLE with req=0: remain IDLE, outputs unchanged.
REQ-014 GRANT with gnt_ready=0: gnt_idx, gnt_onehot, gnt_valid held stable regardless of req changes, including req bit of the granted index dropping (no retraction).
REQ-015 Handshake = gnt_valid & gnt_ready on a rising edge.
REQ-016 Handshake with |req=1 that cycle: load new winner from current req and stay GRANT (back-to-back, one grant per cycle maximum throughput).
REQ-017 Handshake with req=0: go IDLE; gnt_valid=0 and gnt_onehot=0 next cycle; gnt_idx retains last value.
REQ-018 Winner computation on a handshake uses ptr after the same-edge update defined in REQ-024/025 (i.e. the just-accepted index is already lowest priority in RR mode).
REQ-019 gnt_onehot == (1 << gnt_idx) whenever gnt_valid=1; exactly one bit set.
REQ-020 gnt_ready while gnt_valid=0 is ignored.
REQ-021 Purely combinational req-to-output paths forbidden; all outputs driven from flops.

Reset
REQ-022 rst=1 at an edge: state IDLE, gnt_valid=0, gnt_idx=0, gnt_onehot=0, ptr=0; overrides any same-cycle req/handshake.
REQ-023 Reset mid-GRANT discards the pending grant; no handshake is recorded; first grant after reset uses ptr=0 order.

Configuration
REQ-024 Macro PRIO_ARBITER_RR_EN defined: round-robin; on each handshake ptr <= accepted gnt_idx, so the accepted requester becomes lowest priority and its lower neighbour highest.
REQ-025 Macro undefined: fixed priority; ptr constantly 0, highest set req index always wins; no ptr flop is synthesised.

Verification
REQ-026 OUT_WIDTH=3, reset then req=8'h00 for 10 cycles -> gnt_valid=0, gnt_onehot=8'h00 every cycle.
REQ-027 IDLE, req=8'h24 one cycle -> next cycle gnt_valid=1, gnt_idx=5, gnt_onehot=8'h20.
REQ-028 Holding grant idx 5, gnt_ready=0 for 3 cycles while req changes to 8'h80 then 8'h00 -> gnt_idx=5, gnt_valid=1 throughout; ready=1 with req=8'h00 -> IDLE next cycle.
REQ-029 req=8'hFF constant, gnt_ready=1: with PRIO_ARBITER_RR_EN gnt_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles; without macro 7 every cycle.
REQ-030 RR mode, grant idx 2 outstanding, rst=1 one cycle, then req=8'h09 -> gnt_valid=0 after reset edge, then gnt_idx=3 (ptr=0 order), not 0.
REQ-031 OUT_WIDTH=1, req=2'b11, ready=1, RR on -> gnt_idx alternates 1,0,1; req=2'b01 -> gnt_idx=0 every cycle.
